// File: rtl/signed_accum_ctrl.sv
// -----------------------------------------------------------------------------
// signed_accum_ctrl
//
// Sign/accumulate sequencer for ternary-weight (+1 / -1 / 0) partial results
// coming out of the CiM macro. A frame of cfg_len signed beats is taken on a
// valid/ready input. Each beat is negated, passed through or zeroed according
// to its weight class, then added into a saturating accumulator. One result
// per frame is presented on a valid/ready output.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      frame start pulse, honoured only in IDLE
//   cfg_len    beats in the frame, sampled on an accepted start
//   in_valid   beat valid
//   in_ready   block accepts a beat this cycle (high throughout ACCUM)
//   in_data    signed partial result
//   in_sign    weight -1: negate the term
//   in_zero    weight 0: term forced to zero (wins over in_sign)
//   out_valid  accumulated result valid
//   out_ready  downstream accepts the result
//   out_data   saturated signed accumulated result
//   out_ovf    saturation occurred somewhere in this frame
//   busy       high in ACCUM or DONE
// -----------------------------------------------------------------------------
module signed_accum_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 20,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sign,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W:0]   sext_data;
    logic [ACC_W:0]   term;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;

    assign accept = in_valid & in_ready;
    assign busy   = (state != S_IDLE);

    // Extend to ACC_W+1 bits before negating so that the most negative input
    // negates to its exact positive magnitude instead of wrapping.
    assign sext_data = {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        term    = '0;
        sum     = '0;
        acc_nxt = acc;
        ovf_nxt = ovf;
        if (!in_zero) begin
            term = in_sign ? (~sext_data + 1'b1) : sext_data;
        end
        sum = {acc[ACC_W-1], acc} + term;
        // Both operands are in range, so the sum fits in ACC_W+1 bits and the
        // top two bits disagree exactly when the result leaves the ACC_W range.
        if (!sum[ACC_W] && sum[ACC_W-1]) begin
            acc_nxt = ACC_MAX;
            ovf_nxt = 1'b1;
        end else if (sum[ACC_W] && !sum[ACC_W-1]) begin
            acc_nxt = ACC_MIN;
            ovf_nxt = 1'b1;
        end else begin
            acc_nxt = sum[ACC_W-1:0];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other register, whatever the order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (cfg_len != '0) begin
                            cnt      <= cfg_len;
                            in_ready <= 1'b1;
                            state    <= S_ACCUM;
                        end else begin
                            // Empty frame: present a zero result immediately.
                            out_data  <= '0;
                            out_ovf   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end

                S_ACCUM: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        ovf <= ovf_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            // Result includes the beat being accepted now.
                            out_data  <= acc_nxt;
                            out_ovf   <= ovf_nxt;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
